// File: rtl/iic_pkg.sv
// Shared I2C target definitions: FSM encoding, byte framing and default addressing/page constants.
package iic_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StDev,
    StDevAck,
    StWah,
    StWahAck,
    StWal,
    StWalAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdMack,
    StIgnore
  } iic_state_e;

  localparam int unsigned IicBits        = 8;
  localparam logic [6:0]  IicDevAddr     = 7'b1010000;
  localparam int unsigned IicPageSize    = 32;
  localparam int unsigned IicClkFreq     = 50_000_000;
  // tWR in microseconds times this gives the TWR_CYCLES value for the board clock
  localparam int unsigned IicCyclesPerUs = IicClkFreq / 1_000_000;

endpackage

// File: rtl/iic_eeprom_slave_if.sv
// Status bundle of the EEPROM target: write-cycle state, address pointer and bus activity.
interface iic_eeprom_slave_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              busy;
  logic              wr_done;
  logic [ADDR_W-1:0] addr_ptr;
  logic              bus_active;

  modport slave (output busy, wr_done, addr_ptr, bus_active);
  modport master (input busy, wr_done, addr_ptr, bus_active);
endinterface

// File: rtl/iic_bus_monitor.sv
// Synchronises scl/sda into sys_clk and flags scl edges plus START/STOP conditions.
module iic_bus_monitor (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl_s, sda_s;

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // Released bus idles high, so reset to 1 to avoid a spurious edge after reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/iic_eeprom_slave.sv
// 24Cxx-style I2C EEPROM target with page write, sequential read and tWR/ACK-polling emulation.
// Define IIC_EEPROM_WP_EN to add the wp write-protect input.
module iic_eeprom_slave
  import iic_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = IicDevAddr,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned PAGE_SIZE  = IicPageSize,
  parameter logic [31:0] TWR_CYCLES = 32'd1000,
  parameter logic [7:0]  MEM_INIT   = 8'hFF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic scl,
  inout  wire  sda,
`ifdef IIC_EEPROM_WP_EN
  input  logic wp,
`endif
  iic_eeprom_slave_if.slave status
);

  localparam int unsigned       Depth    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PageMask = ADDR_W'(PAGE_SIZE - 1);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [31:0]       TwrLoad  = (TWR_CYCLES == 32'd0) ? 32'd0 : TWR_CYCLES - 32'd1;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  iic_bus_monitor u_bus_monitor (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .scl_i      (scl),
    .sda_i      (sda),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  iic_state_e        state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        wah_q, wah_d;
  logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
  logic              write_pending_q, write_pending_d;
  logic              busy_q, busy_d;
  logic [31:0]       twr_cnt_q, twr_cnt_d;
  logic              wr_done_q, wr_done_d;
  logic              bus_active_q, bus_active_d;
  logic              sda_drive_q, sda_drive_d;
  logic              fall_q, fall_d;
  logic [7:0]        mem_q [Depth];
  logic              mem_we;
  logic [7:0]        byte_in;
  logic [15:0]       word_addr;
  logic              last_bit;
  logic              wr_allow;

`ifdef IIC_EEPROM_WP_EN
  logic [1:0] wp_q, wp_d;
  assign wp_d     = {wp_q[0], wp};
  assign wr_allow = ~wp_q[1];
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) wp_q <= 2'b00;
    else            wp_q <= wp_d;
  end
`else
  assign wr_allow = 1'b1;
`endif

  assign byte_in   = {shift_q[6:0], sda_s};
  assign word_addr = {wah_q, shift_q};
  assign last_bit  = (bit_cnt_q == 4'(IicBits - 1));
  assign fall_d    = scl_fall;

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    wah_d           = wah_q;
    addr_ptr_d      = addr_ptr_q;
    write_pending_d = write_pending_q;
    busy_d          = busy_q;
    twr_cnt_d       = twr_cnt_q;
    wr_done_d       = 1'b0;
    bus_active_d    = bus_active_q;
    sda_drive_d     = sda_drive_q;
    mem_we          = 1'b0;

    if (busy_q) begin
      if (twr_cnt_q == 32'd0) begin
        busy_d    = 1'b0;
        wr_done_d = 1'b1;
      end else begin
        twr_cnt_d = twr_cnt_q - 32'd1;
      end
    end

    if (scl_rise) begin
      case (state_q)
        StDev: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          // A busy part stays silent so the master can ACK-poll the write cycle
          if (last_bit) state_d = (byte_in[7:1] == DEV_ADDR && !busy_q) ? StDevAck : StIgnore;
        end
        StDevAck: begin
          bit_cnt_d = 4'd0;
          if (shift_q[0]) begin
            state_d = StRdata;
            shift_d = mem_q[addr_ptr_q];
          end else begin
            state_d = StWah;
          end
        end
        StWah: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (last_bit) begin
            wah_d   = byte_in;
            state_d = StWahAck;
          end
        end
        StWahAck: begin
          bit_cnt_d = 4'd0;
          state_d   = StWal;
        end
        StWal: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (last_bit) state_d = StWalAck;
        end
        StWalAck: begin
          bit_cnt_d  = 4'd0;
          addr_ptr_d = word_addr[ADDR_W-1:0];
          state_d    = StWdata;
        end
        StWdata: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (last_bit) begin
            mem_we          = wr_allow;
            write_pending_d = write_pending_q | wr_allow;
            addr_ptr_d      = (addr_ptr_q & ~PageMask) | ((addr_ptr_q + AddrOne) & PageMask);
            state_d         = StWdataAck;
          end
        end
        StWdataAck: begin
          bit_cnt_d = 4'd0;
          state_d   = StWdata;
        end
        StRdata: begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (last_bit) begin
            addr_ptr_d = addr_ptr_q + AddrOne;
            state_d    = StRdMack;
          end
        end
        StRdMack: begin
          bit_cnt_d = 4'd0;
          if (!sda_s) begin
            state_d = StRdata;
            shift_d = mem_q[addr_ptr_q];
          end else begin
            state_d = StIgnore;
          end
        end
        default: ;
      endcase
    end

    // Drive changes land one cycle after the synced scl fall, well inside scl low
    if (fall_q) begin
      case (state_q)
        StDevAck, StWahAck, StWalAck, StWdataAck: sda_drive_d = 1'b1;
        StRdata:                                  sda_drive_d = ~shift_q[7];
        default:                                  sda_drive_d = 1'b0;
      endcase
    end

    if (start_det) begin
      state_d      = StDev;
      bit_cnt_d    = 4'd0;
      bus_active_d = 1'b1;
      sda_drive_d  = 1'b0;
    end

    // STOP is applied last so a byte finishing this cycle is already committed
    if (stop_det) begin
      state_d      = StIdle;
      bit_cnt_d    = 4'd0;
      bus_active_d = 1'b0;
      sda_drive_d  = 1'b0;
      if (write_pending_d) begin
        write_pending_d = 1'b0;
        busy_d          = 1'b1;
        twr_cnt_d       = TwrLoad;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q         <= StIdle;
      bit_cnt_q       <= 4'd0;
      shift_q         <= 8'd0;
      wah_q           <= 8'd0;
      addr_ptr_q      <= '0;
      write_pending_q <= 1'b0;
      busy_q          <= 1'b0;
      twr_cnt_q       <= 32'd0;
      wr_done_q       <= 1'b0;
      bus_active_q    <= 1'b0;
      sda_drive_q     <= 1'b0;
      fall_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      wah_q           <= wah_d;
      addr_ptr_q      <= addr_ptr_d;
      write_pending_q <= write_pending_d;
      busy_q          <= busy_d;
      twr_cnt_q       <= twr_cnt_d;
      wr_done_q       <= wr_done_d;
      bus_active_q    <= bus_active_d;
      sda_drive_q     <= sda_drive_d;
      fall_q          <= fall_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= MEM_INIT;
    end else if (mem_we) begin
      mem_q[addr_ptr_q] <= byte_in;
    end
  end

  assign sda               = sda_drive_q ? 1'b0 : 1'bz;
  assign status.busy       = busy_q;
  assign status.wr_done    = wr_done_q;
  assign status.addr_ptr   = addr_ptr_q;
  assign status.bus_active = bus_active_q;

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Directed bench for iic_eeprom_slave: drives a bit-banged I2C master and checks against hand-computed values.
module tb_iic_eeprom_slave;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic scl       = 1'b1;
  logic m_low     = 1'b0;
  wire  sda;

  int vectors     = 0;
  int miscompares = 0;
  int wr_done_cnt = 0;
  int dut_low_cnt = 0;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  iic_eeprom_slave_if #(.ADDR_W(8)) st_if ();

`ifdef IIC_EEPROM_WP_EN
  logic wp = 1'b0;
`endif

  iic_eeprom_slave #(
    .DEV_ADDR   (7'b1010000),
    .ADDR_W     (8),
    .PAGE_SIZE  (32),
    .TWR_CYCLES (32'd300),
    .MEM_INIT   (8'hFF)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .scl       (scl),
    .sda       (sda),
`ifdef IIC_EEPROM_WP_EN
    .wp        (wp),
`endif
    .status    (st_if)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (st_if.wr_done) wr_done_cnt <= wr_done_cnt + 1;
    if (!m_low && sda === 1'b0) dut_low_cnt <= dut_low_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wbit(input logic b);
    m_low = ~b;
    tick(5); scl = 1'b1;
    tick(5); scl = 1'b0;
    tick(5);
  endtask

  task automatic rbit(output logic b);
    m_low = 1'b0;
    tick(5); scl = 1'b1;
    tick(3); b = sda;
    tick(2); scl = 1'b0;
    tick(5);
  endtask

  task automatic i2c_start();
    m_low = 1'b0;
    tick(5); scl = 1'b1;
    tick(5); m_low = 1'b1;
    tick(5); scl = 1'b0;
    tick(5);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    tick(5); scl = 1'b1;
    tick(5); m_low = 1'b0;
    tick(5);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(a);
    ack = ~a;
  endtask

  task automatic rbyte(output logic [7:0] d, input logic mack);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      rbit(bt);
      d[i] = bt;
    end
    wbit(~mack);
  endtask

  task automatic set_addr(input logic [15:0] a, input string tag);
    logic ack;
    i2c_start();
    wbyte(8'hA0, ack);  chk({tag, "_dev_ack"}, ack, 1);
    wbyte(a[15:8], ack); chk({tag, "_wah_ack"}, ack, 1);
    wbyte(a[7:0], ack);  chk({tag, "_wal_ack"}, ack, 1);
  endtask

  // exp holds up to four bytes, first byte read in the top octet
  task automatic rd_seq(input logic [15:0] a, input int n, input logic [31:0] exp,
                        input string tag);
    logic       ack;
    logic [7:0] d;
    set_addr(a, tag);
    i2c_start();
    wbyte(8'hA1, ack); chk({tag, "_rd_ack"}, ack, 1);
    for (int i = 0; i < n; i++) begin
      rbyte(d, i != n - 1);
      chk($sformatf("%s_byte%0d", tag, i), d, exp[31-8*i -: 8]);
    end
    i2c_stop();
  endtask

  task automatic wait_not_busy(input string tag);
    int n;
    n = 0;
    while (st_if.busy === 1'b1 && n < 5000) begin
      tick(1);
      n++;
    end
    chk(tag, st_if.busy, 0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] pdata [4];
    int         base;

    pdata[0] = 8'h11; pdata[1] = 8'h22; pdata[2] = 8'h33; pdata[3] = 8'h44;

    tick(3);
    sys_rst_n = 1'b1;
    tick(3);
    chk("rst_busy", st_if.busy, 0);
    chk("rst_wr_done", st_if.wr_done, 0);
    chk("rst_addr_ptr", st_if.addr_ptr, 0);
    chk("rst_bus_active", st_if.bus_active, 0);
    chk("rst_sda", sda, 1);

    // Single byte write 0x0010 <- A5
    base = wr_done_cnt;
    set_addr(16'h0010, "wr");
    wbyte(8'hA5, ack); chk("wr_data_ack", ack, 1);
    chk("wr_bus_active", st_if.bus_active, 1);
    chk("wr_addr_ptr", st_if.addr_ptr, 8'h11);
    i2c_stop();
    chk("wr_busy_after_stop", st_if.busy, 1);
    chk("wr_bus_idle", st_if.bus_active, 0);

    // ACK polling during tWR
    i2c_start();
    wbyte(8'hA0, ack); chk("poll_nack", ack, 0);
    chk("poll_busy", st_if.busy, 1);
    i2c_stop();
    wait_not_busy("twr_end");
    tick(2);
    chk("wr_done_once", wr_done_cnt - base, 1);
    i2c_start();
    wbyte(8'hA0, ack); chk("poll_ack", ack, 1);
    i2c_stop();
    tick(3);
    chk("dev_only_no_twr", st_if.busy, 0);

    // Random read back
    rd_seq(16'h0010, 1, 32'hA5000000, "rr");
    chk("rr_addr_ptr", st_if.addr_ptr, 8'h11);

    // Page write wrapping at the 32-byte boundary
    set_addr(16'h001E, "pg");
    for (int i = 0; i < 4; i++) begin
      wbyte(pdata[i], ack);
      chk($sformatf("pg_data_ack%0d", i), ack, 1);
    end
    i2c_stop();
    chk("pg_addr_ptr", st_if.addr_ptr, 8'h02);
    wait_not_busy("pg_twr_end");
    rd_seq(16'h001E, 3, 32'h1122FF00, "pg_hi");
    rd_seq(16'h0000, 2, 32'h33440000, "pg_lo");

    // Sequential read across the end of memory
    rd_seq(16'h00FE, 4, 32'hFFFF3344, "seq");
    chk("seq_addr_ptr", st_if.addr_ptr, 8'h02);

    // Address mismatch is ignored and never pulls sda
    base = dut_low_cnt;
    i2c_start();
    wbyte(8'hA2, ack); chk("mis_nack", ack, 0);
    wbyte(8'h00, ack);
    wbyte(8'h10, ack);
    wbyte(8'h5A, ack);
    i2c_stop();
    chk("mis_sda_never_low", dut_low_cnt - base, 0);
    chk("mis_no_twr", st_if.busy, 0);
    rd_seq(16'h0010, 1, 32'hA5000000, "mis_mem");

    // Reset while the target drives a 0 data bit (mem[01] = 44, MSB 0)
    set_addr(16'h0001, "rs");
    i2c_start();
    wbyte(8'hA1, ack); chk("rs_rd_ack", ack, 1);
    chk("rs_drive_low", sda, 0);
    chk("rs_addr_ptr", st_if.addr_ptr, 8'h01);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("rs_sda_release", sda, 1);
    chk("rs_busy", st_if.busy, 0);
    chk("rs_addr_ptr_clr", st_if.addr_ptr, 0);
    chk("rs_bus_active", st_if.bus_active, 0);
    tick(2);
    scl = 1'b1;
    m_low = 1'b0;
    tick(3);
    sys_rst_n = 1'b1;
    tick(3);
    rd_seq(16'h0010, 1, 32'hFF000000, "rs_mem_init");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
